// File: rtl/afifo_rd_stream_if.sv
// Read-port and stream bundle for afifo_rd_stream.
//   master : the reader. Drives fifo_rd_en, m_valid and m_data; takes fifo_empty,
//            fifo_data and m_ready.
//   slave  : the FIFO read port plus the downstream consumer, seen from outside the reader.
// Signals:
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read enable
//   fifo_data   FIFO read data, valid the cycle after an accepted read
//   m_valid     stream word valid
//   m_ready     stream consumer ready
//   m_data      stream word
interface afifo_rd_stream_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/afifo_rd_stream.sv
// Read-side consumer for the dual-clock Gray-pointer FIFO. Issues FIFO reads under a credit
// rule, captures the read data one RClk later, and presents the words as a valid/ready
// stream through a 2-entry skid buffer. Sustains one word per cycle and drops nothing
// under backpressure.
// Ports:
//   RClk        read-domain clock, all state on the rising edge
//   PresetFull  asynchronous active-high reset
//   flush       synchronous discard of buffered and in-flight words
//   word_cnt    count of words accepted downstream, wraps
//   bus         FIFO read port and output stream (master side)
module afifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                   RClk,
    input  logic                   PresetFull,
    input  logic                   flush,
    output logic [CNT_WIDTH-1:0]   word_cnt,
    afifo_rd_stream_if.master      bus
);

    // Encoding equals the number of buffered words.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic                  r_pend;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] w_head_d;
    logic [DATA_WIDTH-1:0] w_tail_d;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_rd_en;
    logic [2:0]            w_occ;
    logic [2:0]            w_lim;

    always_comb begin
        w_pop  = (r_state != StEmpty) & bus.m_ready;
        w_push = r_pend & ~flush;
        // count + pend - pop < 2, rearranged to avoid an unsigned underflow.
        w_occ   = 3'(r_state) + 3'(r_pend);
        w_lim   = 3'd2 + 3'(w_pop);
        w_rd_en = ~bus.fifo_empty & ~flush & ~PresetFull & (w_occ < w_lim);
    end

    always_comb begin
        w_state_d = r_state;
        w_head_d  = r_head;
        w_tail_d  = r_tail;
        unique case (r_state)
            StEmpty: begin
                if (w_push) begin
                    w_state_d = StOne;
                    w_head_d  = bus.fifo_data;
                end
            end
            StOne: begin
                if (w_push && !w_pop) begin
                    w_state_d = StTwo;
                    w_tail_d  = bus.fifo_data;
                end else if (w_pop && !w_push) begin
                    w_state_d = StEmpty;
                end else if (w_push && w_pop) begin
                    w_head_d = bus.fifo_data;
                end
            end
            StTwo: begin
                // Credit rule never lets a push arrive here without a pop.
                if (w_pop) begin
                    w_head_d = r_tail;
                    if (w_push) begin
                        w_tail_d = bus.fifo_data;
                    end else begin
                        w_state_d = StOne;
                    end
                end
            end
            default: w_state_d = StEmpty;
        endcase
        if (flush) begin
            w_state_d = StEmpty;
        end
    end

    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            r_state <= StEmpty;
            r_pend  <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_pend  <= w_rd_en;
            r_head  <= w_head_d;
            r_tail  <= w_tail_d;
            // A handshake completed at a flush edge still counts as delivered.
            r_cnt   <= r_cnt + CNT_WIDTH'(w_pop);
        end
    end

    always_comb begin
        bus.fifo_rd_en = w_rd_en;
        bus.m_valid    = (r_state != StEmpty);
        bus.m_data     = r_head;
        word_cnt       = r_cnt;
    end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Directed bench for afifo_rd_stream: behavioural FIFO read port, scoreboard of expected
// stream words, invariant monitor, and a second instance with a 4-bit counter for wrap.
module tb_afifo_rd_stream;

    localparam int unsigned DW       = 8;
    localparam int unsigned MemDepth = 2048;

    logic        RClk = 1'b0;
    logic        PresetFull;
    logic        flush;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt_w;
    logic        flush_w;

    afifo_rd_stream_if #(.DATA_WIDTH(DW)) u_if ();
    afifo_rd_stream_if #(.DATA_WIDTH(DW)) u_if_w ();

    afifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) u_dut (
        .RClk       (RClk),
        .PresetFull (PresetFull),
        .flush      (flush),
        .word_cnt   (word_cnt),
        .bus        (u_if.master)
    );

    afifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_dut_w (
        .RClk       (RClk),
        .PresetFull (PresetFull),
        .flush      (flush_w),
        .word_cnt   (word_cnt_w),
        .bus        (u_if_w.master)
    );

    always #5 RClk = ~RClk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural FIFO read port: data registered one RClk after an accepted read.
    logic [7:0]  mem [MemDepth];
    int unsigned wr_ptr  = 0;
    int unsigned rd_ptr  = 0;
    int unsigned n_reads = 0;

    assign u_if.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge RClk) begin
        if (u_if.fifo_rd_en) begin
            u_if.fifo_data <= mem[rd_ptr % MemDepth];
            rd_ptr         <= rd_ptr + 1;
            n_reads        <= n_reads + 1;
        end
    end

    // Reference model: delivered-word count and buffered+in-flight occupancy.
    logic [7:0]  exp_q[$];
    int unsigned exp_cnt;
    int          occ;
    bit          sb_en = 1'b0;

    always @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            exp_cnt <= 0;
            occ     <= 0;
        end else begin
            if (u_if.m_valid && u_if.m_ready) exp_cnt <= exp_cnt + 1;
            if (flush) occ <= 0;
            else occ <= occ - int'(u_if.m_valid && u_if.m_ready) + int'(u_if.fifo_rd_en);
        end
    end

    logic       prev_stall = 1'b0;
    logic       prev_flush = 1'b0;
    logic [7:0] prev_data  = '0;

    always @(negedge RClk) begin
        if (sb_en && !PresetFull) begin
            if (u_if.fifo_empty) check_eq("rd_while_empty", 32'(u_if.fifo_rd_en), 0);
            if (flush) check_eq("rd_while_flush", 32'(u_if.fifo_rd_en), 0);
            check_eq("occupancy_le2", 32'(occ <= 2), 1);
            check_eq("word_cnt", 32'(word_cnt), 32'(16'(exp_cnt)));
            if (prev_stall && !prev_flush) begin
                check_eq("hold_valid", 32'(u_if.m_valid), 1);
                check_eq("hold_data", 32'(u_if.m_data), 32'(prev_data));
            end
            if (u_if.m_valid && u_if.m_ready) begin
                check_eq("sb_word_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check_eq("sb_order", 32'(u_if.m_data), 32'(exp_q.pop_front()));
            end
        end
        prev_stall <= u_if.m_valid && !u_if.m_ready;
        prev_flush <= flush;
        prev_data  <= u_if.m_data;
    end

    task automatic tick();
        @(posedge RClk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d, input bit expect_out);
        mem[wr_ptr % MemDepth] = d;
        wr_ptr = wr_ptr + 1;
        if (expect_out) exp_q.push_back(d);
    endtask

    task automatic wait_cnt(input logic [15:0] target, input int unsigned budget, input string tag);
        int unsigned cyc = 0;
        while (word_cnt != target && cyc < budget) begin
            tick();
            cyc++;
        end
        check_eq(tag, 32'(word_cnt), 32'(target));
    endtask

    initial begin
        int unsigned n0;
        int unsigned pushed;
        int unsigned cyc;

        PresetFull        = 1'b1;
        flush             = 1'b0;
        flush_w           = 1'b0;
        u_if.m_ready      = 1'b0;
        u_if_w.m_ready    = 1'b0;
        u_if_w.fifo_empty = 1'b1;
        u_if_w.fifo_data  = 8'h5A;

        // Reset state
        repeat (3) tick();
        check_eq("rst_m_valid", 32'(u_if.m_valid), 0);
        check_eq("rst_m_data", 32'(u_if.m_data), 0);
        check_eq("rst_word_cnt", 32'(word_cnt), 0);
        check_eq("rst_rd_en", 32'(u_if.fifo_rd_en), 0);
        PresetFull = 1'b0;
        sb_en      = 1'b1;

        // Streaming: 16 words, two-edge latency, then one word per cycle
        u_if.m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push_word(8'(i), 1'b1);
        @(negedge RClk);
        check_eq("stream_rd_en", 32'(u_if.fifo_rd_en), 1);
        check_eq("stream_lat0", 32'(u_if.m_valid), 0);
        @(negedge RClk);
        check_eq("stream_lat1", 32'(u_if.m_valid), 0);
        @(negedge RClk);
        for (int i = 1; i <= 16; i++) begin
            check_eq("stream_valid", 32'(u_if.m_valid), 1);
            check_eq("stream_data", 32'(u_if.m_data), 32'(i));
            @(negedge RClk);
        end
        check_eq("stream_drained", 32'(u_if.m_valid), 0);
        check_eq("stream_cnt", 32'(word_cnt), 16);
        check_eq("stream_rd_idle", 32'(u_if.fifo_rd_en), 0);

        // Backpressure: only two reads while stalled, head held, gapless restart
        tick();
        u_if.m_ready = 1'b0;
        n0 = n_reads;
        for (int i = 1; i <= 8; i++) push_word(8'(i), 1'b1);
        repeat (10) tick();
        check_eq("bp_reads", n_reads - n0, 2);
        check_eq("bp_valid", 32'(u_if.m_valid), 1);
        check_eq("bp_head", 32'(u_if.m_data), 1);
        u_if.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge RClk);
            check_eq("bp_valid_run", 32'(u_if.m_valid), 1);
            check_eq("bp_data_run", 32'(u_if.m_data), 32'(i));
        end
        @(negedge RClk);
        check_eq("bp_cnt", 32'(word_cnt), 24);

        // Random ready and trickling FIFO fill, 1000 words
        tick();
        pushed = 0;
        cyc    = 0;
        while (word_cnt != 16'd1024 && cyc < 20000) begin
            u_if.m_ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 9) < 6) begin
                push_word(8'(pushed * 7 + 3), 1'b1);
                pushed++;
            end
            tick();
            cyc++;
        end
        u_if.m_ready = 1'b0;
        check_eq("rand_cnt", 32'(word_cnt), 1024);
        check_eq("rand_sb_drained", 32'(exp_q.size()), 0);

        // Flush: A2 buffered and A3 in flight are discarded, A4 follows
        tick();
        n0 = n_reads;
        push_word(8'hA1, 1'b1);
        push_word(8'hA2, 1'b0);
        push_word(8'hA3, 1'b0);
        push_word(8'hA4, 1'b1);
        repeat (4) tick();
        check_eq("fl_reads", n_reads - n0, 2);
        check_eq("fl_head", 32'(u_if.m_data), 32'h A1);
        u_if.m_ready = 1'b1;
        tick();
        u_if.m_ready = 1'b0;
        flush        = 1'b1;
        check_eq("fl_cnt_pre", 32'(word_cnt), 1025);
        @(negedge RClk);
        check_eq("fl_no_read", 32'(u_if.fifo_rd_en), 0);
        check_eq("fl_head2", 32'(u_if.m_data), 32'h A2);
        tick();
        flush = 1'b0;
        @(negedge RClk);
        check_eq("fl_valid_low", 32'(u_if.m_valid), 0);
        check_eq("fl_cnt_post", 32'(word_cnt), 1025);
        u_if.m_ready = 1'b1;
        wait_cnt(16'd1026, 20, "fl_next_word");
        check_eq("fl_sb_drained", 32'(exp_q.size()), 0);

        // Asynchronous reset mid-stream
        sb_en = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) push_word(8'(8'hC0 + i), 1'b0);
        repeat (4) tick();
        check_eq("ar_pre_valid", 32'(u_if.m_valid), 1);
        PresetFull = 1'b1;
        #2;
        check_eq("ar_m_valid", 32'(u_if.m_valid), 0);
        check_eq("ar_m_data", 32'(u_if.m_data), 0);
        check_eq("ar_word_cnt", 32'(word_cnt), 0);
        check_eq("ar_rd_en", 32'(u_if.fifo_rd_en), 0);
        repeat (2) tick();
        wr_ptr = rd_ptr;
        exp_q.delete();
        PresetFull   = 1'b0;
        sb_en        = 1'b1;
        u_if.m_ready = 1'b0;

        // Counter wrap on the 4-bit instance: 17 words -> 1
        u_if_w.fifo_empty = 1'b0;
        repeat (4) tick();
        check_eq("wrap_valid", 32'(u_if_w.m_valid), 1);
        check_eq("wrap_cnt0", 32'(word_cnt_w), 0);
        u_if_w.m_ready = 1'b1;
        repeat (17) tick();
        u_if_w.m_ready    = 1'b0;
        u_if_w.fifo_empty = 1'b1;
        @(negedge RClk);
        check_eq("wrap_cnt", 32'(word_cnt_w), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
